// File: rtl/mdu_scheduler.sv
// mdu_scheduler: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EXE stage.
// A fixed-latency multiplier or a 32-step restoring divider runs in the
// background. The HI/LO result is held until EXE advances.
// Optional feature macro: MDU_EARLY_OUT_EN. When it is defined, a divide with
// |dividend| < |divisor| (divisor non-zero) completes in the start cycle.
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   EXE_MulDivReq/Op      request valid and op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   EXE_OperandA/B        rs / rt operands
//   EXE_Wr                EXE stage register advances (consumes the result)
//   Flush_Exception       aborts any operation in flight
//   DIVMULTBusy           stall request to Control (combinational)
//   MulDiv_Valid          HI/LO result valid
//   MulDiv_HI/LO          result: product high/low, or remainder/quotient
module mdu_scheduler #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        EXE_MulDivReq,
  input  logic [1:0]  EXE_MulDivOp,
  input  logic [31:0] EXE_OperandA,
  input  logic [31:0] EXE_OperandB,
  input  logic        EXE_Wr,
  input  logic        Flush_Exception,
  output logic        DIVMULTBusy,
  output logic        MulDiv_Valid,
  output logic [31:0] MulDiv_HI,
  output logic [31:0] MulDiv_LO
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(31);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, bmag_q, bmag_d;
  logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic              sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;

  // Start-cycle decode: operand magnitudes for the signed ops
  logic            start_c, op_sgn_c, early_c;
  logic [XLEN-1:0] amag_c, bmag_c;

  assign start_c  = (state_q == S_IDLE) & EXE_MulDivReq & ~Flush_Exception;
  assign op_sgn_c = ~EXE_MulDivOp[0];
  assign amag_c   = (op_sgn_c & EXE_OperandA[XLEN-1]) ? XLEN'(-EXE_OperandA) : EXE_OperandA;
  assign bmag_c   = (op_sgn_c & EXE_OperandB[XLEN-1]) ? XLEN'(-EXE_OperandB) : EXE_OperandB;

`ifdef MDU_EARLY_OUT_EN
  assign early_c = EXE_MulDivOp[1] & (EXE_OperandB != '0) & (amag_c < bmag_c);
`else
  assign early_c = 1'b0;
`endif

  // Full 64-bit product; sign-extending the operands makes one multiplier serve both ops
  logic [2*XLEN-1:0] a_ext_c, b_ext_c, prod_c;
  assign a_ext_c = sgn_q ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
  assign b_ext_c = sgn_q ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
  assign prod_c  = a_ext_c * b_ext_c;

  // One restoring divide step: shift the next dividend bit into the partial remainder
  logic [XLEN:0]   part_c;
  logic            ge_c;
  logic [XLEN-1:0] rem_step_c, quo_step_c;
  assign part_c     = {rem_q, quo_q[XLEN-1]};
  assign ge_c       = part_c >= {1'b0, bmag_q};
  assign rem_step_c = ge_c ? XLEN'(part_c - {1'b0, bmag_q}) : part_c[XLEN-1:0];
  assign quo_step_c = {quo_q[XLEN-2:0], ge_c};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (EXE_MulDivReq) state_d = EXE_MulDivOp[1] ? (early_c ? S_DONE : S_DIV) : S_MUL;
      S_MUL:  if (cnt_q == '0) state_d = S_DONE;
      S_DIV:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE: if (EXE_Wr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (Flush_Exception) state_d = S_IDLE;
  end

  // Datapath / output next-values
  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    bmag_d = bmag_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    sgn_d  = sgn_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (Flush_Exception) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_c) begin
          a_d    = EXE_OperandA;
          b_d    = EXE_OperandB;
          bmag_d = bmag_c;
          quo_d  = amag_c;
          rem_d  = '0;
          sgn_d  = op_sgn_c;
          qneg_d = op_sgn_c & (EXE_OperandA[XLEN-1] ^ EXE_OperandB[XLEN-1]);
          rneg_d = op_sgn_c & EXE_OperandA[XLEN-1];
          cnt_d  = EXE_MulDivOp[1] ? DIV_LOAD : MUL_LOAD;
          if (early_c) begin
            cnt_d = '0;
            hi_d  = EXE_OperandA;
            lo_d  = '0;
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            hi_d = prod_c[2*XLEN-1:XLEN];
            lo_d = prod_c[XLEN-1:0];
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DIV: begin
          rem_d = rem_step_c;
          quo_d = quo_step_c;
          if (cnt_q == '0) begin
            if (b_q == '0) begin
              hi_d = a_q;
              lo_d = '1;
            end else begin
              hi_d = rneg_q ? XLEN'(-rem_step_c) : rem_step_c;
              lo_d = qneg_q ? XLEN'(-quo_step_c) : quo_step_c;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      bmag_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      sgn_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      bmag_q <= bmag_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      sgn_q  <= sgn_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end

  // Busy is combinational so Control stalls in the start cycle; reset and flush mask it
  assign DIVMULTBusy  = resetn & ~Flush_Exception &
                        ((state_q == S_MUL) | (state_q == S_DIV) |
                         ((state_q == S_IDLE) & EXE_MulDivReq));
  assign MulDiv_Valid = (state_q == S_DONE);
  assign MulDiv_HI    = hi_q;
  assign MulDiv_LO    = lo_q;

endmodule

// File: doc/mdu_scheduler.md
# mdu_scheduler

Multi-cycle multiply/divide sequencer in the EXE stage. It accepts one MULT/MULTU/DIV/DIVU request at a time from the EXE stage and runs an internal 32-step restoring divider or a fixed-latency multiplier. It drives `DIVMULTBusy` into the pipeline Control block, which stalls the pipeline while it is high. It presents the HI/LO result until the EXE stage advances, and aborts cleanly on `Flush_Exception`.

## Interface
Parameters:
- `MUL_CYCLES`, default 2: number of cycles spent in MUL state (1..8).

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `EXE_MulDivReq`  in  1  EXE holds a valid mul/div instruction.
- `EXE_MulDivOp`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `EXE_OperandA`  in  32  rs value (multiplicand or dividend).
- `EXE_OperandB`  in  32  rt value (multiplier or divisor).
- `EXE_Wr`  in  1  EXE stage register advances this cycle (from Control).
- `Flush_Exception`  in  1  exception flush; aborts any operation.
- `DIVMULTBusy`  out  1  stall request to Control.
- `MulDiv_Valid`  out  1  HI/LO result valid (DONE state).
- `MulDiv_HI`  out  32  HI result (product high word or remainder).
- `MulDiv_LO`  out  32  LO result (product low word or quotient).

## Operation
States: IDLE, MUL, DIV, DONE.
- IDLE with `EXE_MulDivReq`=1 and no flush (start cycle):
  - Latch the operands, the op, and the sign flags.
  - Signed ops use operand magnitudes.
  - MUL: load counter with `MUL_CYCLES`-1. DIV: load counter with 31, remainder register with 0.
  - Next state is MUL or DIV.
- MUL: compute the full 64-bit product (signed for MULT, unsigned for MULTU). Decrement the counter; at 0, latch the result and go to DONE.
- DIV: one restoring step per cycle, MSB first. Decrement the counter; after step 32 (counter 0), apply sign fix-up and latch the result, then go to DONE.
  - Quotient is negated if the operand signs differ (DIV only).
  - Remainder takes the sign of the dividend.
- Divide by zero: LO=32'hFFFF_FFFF, HI=dividend unchanged. Same latency as a normal divide. No exception.
- DONE: `MulDiv_Valid`=1 and HI/LO are stable.
  - `EXE_Wr`=1: go to IDLE next cycle.
  - `EXE_Wr`=0 (another stall source): stay in DONE. No restart, even though `EXE_MulDivReq` is still high.
- Busy logic:
  - Raw busy = (state ∈ {MUL, DIV}) | (state==IDLE & `EXE_MulDivReq`).
  - `DIVMULTBusy` = raw busy & ~`Flush_Exception`. It is combinational from the request and flush inputs.
- `Flush_Exception`=1 in any state: next state is IDLE. The counter and valid are cleared and no result is produced. Flush wins over a simultaneous start and over DONE.
- Reset (asynchronous, any state, including mid-divide): state=IDLE, counter=0. `DIVMULTBusy`=0, `MulDiv_Valid`=0, `MulDiv_HI`=0, `MulDiv_LO`=0.

## Timing
- MUL: `DIVMULTBusy` is high for `MUL_CYCLES`+1 cycles (start cycle plus MUL cycles). `MulDiv_Valid` rises the cycle after busy falls.
- DIV: `DIVMULTBusy` is high for 33 cycles (start cycle plus 32 steps). `MulDiv_Valid` then rises.
- In DONE, busy is 0 and valid is 1 in the same cycle. Control then raises `EXE_Wr`, and the result is consumed at that edge.
- A back-to-back mul/div can start no earlier than the cycle after DONE→IDLE, because the next instruction reaches EXE on that same edge.
- Outputs HI/LO change only on entry to DONE or on reset.

## Configuration
- `MDU_EARLY_OUT_EN` defined: on a DIV/DIVU start, if |dividend| < |divisor| and divisor ≠ 0, go directly to DONE with LO=0 and HI=dividend. Busy lasts 1 cycle (start cycle only).
- Undefined: every divide takes the full 33 busy cycles, regardless of operand values.

## Test plan
- MULT A=-3, B=7, `MUL_CYCLES`=2 -> busy for 3 cycles, then valid with HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
- DIVU A=100, B=7 -> busy for 33 cycles, then LO=14, HI=2. With `EXE_Wr`=1 in DONE, the block is IDLE on the next cycle.
- DIV A=-7, B=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIV A=5, B=0 -> LO=32'hFFFF_FFFF, HI=5, latency 33.
- `Flush_Exception` pulsed on step 10 of a DIVU -> `DIVMULTBusy`=0 in the same cycle, IDLE next cycle, `MulDiv_Valid` never asserts. Assert `resetn` low on step 20 of another divide -> all outputs 0 immediately.
- `EXE_Wr` held 0 for 5 cycles in DONE with `EXE_MulDivReq` high -> valid and HI/LO stable for all 5 cycles, busy stays 0, no restart.
- With `MDU_EARLY_OUT_EN` defined: DIVU A=3, B=10 -> busy for 1 cycle, LO=0, HI=3. DIVU A=30, B=10 -> full 33-cycle path, LO=3, HI=0.
